// File: rtl/alu_result_stage_pkg.sv
// Shared encodings for the ALU result stage: command opcodes, buffer depth and occupancy states.
// The optional ALU_STAGE_OPCOUNT_EN build adds no package content.
package alu_result_stage_pkg;

  localparam int DEPTH = 2;

  typedef enum logic [1:0] {
    CMD_ADD  = 2'd0,
    CMD_SUB  = 2'd1,
    CMD_SLT  = 2'd2,
    CMD_RSVD = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/alu_result_stage_addsub_core.sv
// Combinational add/subtract/set-less-than evaluation with carry, signed overflow and zero flags.
// SLT and the reserved command report no carry or overflow.
module alu_addsub_core
  import alu_result_stage_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       cmd,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  logic [WIDTH-1:0] b_eff_s;
  logic             cin_s;
  logic [WIDTH:0]   sum_s;
  logic             ovf_s;

  // Shared adder: ADD uses b directly, every other command evaluates a - b
  always_comb begin
    b_eff_s = b;
    cin_s   = 1'b0;
    if (cmd == CMD_ADD) begin
      b_eff_s = b;
      cin_s   = 1'b0;
    end else begin
      b_eff_s = ~b;
      cin_s   = 1'b1;
    end
    sum_s = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, cin_s};
    ovf_s = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
  end

  // Select the final result and flags per command
  always_comb begin
    result   = {WIDTH{1'b0}};
    carryout = 1'b0;
    overflow = 1'b0;
    case (cmd)
      CMD_ADD, CMD_SUB: begin
        result   = sum_s[WIDTH-1:0];
        carryout = sum_s[WIDTH];
        overflow = ovf_s;
      end
      CMD_SLT: begin
        // true signed less-than even when a - b itself overflows
        result   = {{(WIDTH-1){1'b0}}, sum_s[WIDTH-1] ^ ovf_s};
        carryout = 1'b0;
        overflow = 1'b0;
      end
      CMD_RSVD: begin
        result   = {WIDTH{1'b0}};
        carryout = 1'b0;
        overflow = 1'b0;
      end
      default: begin
        result   = {WIDTH{1'b0}};
        carryout = 1'b0;
        overflow = 1'b0;
      end
    endcase
    zero = (result == {WIDTH{1'b0}});
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: valid/ready input, 2-entry ring output buffer, sticky overflow.
// Define ALU_STAGE_OPCOUNT_EN to add the 16-bit op_count debug output.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_cmd,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carryout,
  output logic             out_overflow,
  output logic             out_zero,
  output logic             sticky_ovf,
  input  logic             clr_sticky
`ifdef ALU_STAGE_OPCOUNT_EN
  ,
  output logic [15:0]      op_count
`endif
);

  logic [WIDTH-1:0] core_result_s;
  logic             core_carry_s;
  logic             core_ovf_s;
  logic             core_zero_s;

  logic [WIDTH-1:0] res_mem_r [0:DEPTH-1];
  logic [2:0]       flg_mem_r [0:DEPTH-1];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  occ_e             state_r;
  occ_e             state_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;
  logic             sticky_r;

  alu_addsub_core #(.WIDTH(WIDTH)) u_core (
    .a        (in_a),
    .b        (in_b),
    .cmd      (in_cmd),
    .result   (core_result_s),
    .carryout (core_carry_s),
    .overflow (core_ovf_s),
    .zero     (core_zero_s)
  );

  // Handshake decode and occupancy next-state
  always_comb begin
    state_s   = state_r;
    full_s    = (state_r == OCC_FULL);
    out_valid = (state_r != OCC_EMPTY);
    in_ready  = !full_s || out_ready;
    push_s    = in_valid && in_ready;
    pop_s     = out_valid && out_ready;
    case (state_r)
      OCC_EMPTY: begin
        if (push_s) state_s = OCC_ONE;
        else        state_s = OCC_EMPTY;
      end
      OCC_ONE: begin
        if (push_s && !pop_s)      state_s = OCC_FULL;
        else if (!push_s && pop_s) state_s = OCC_EMPTY;
        else                       state_s = OCC_ONE;
      end
      OCC_FULL: begin
        if (pop_s && !push_s) state_s = OCC_ONE;
        else                  state_s = OCC_FULL;
      end
      default: state_s = OCC_EMPTY;
    endcase
  end

  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= OCC_EMPTY;
    else        state_r <= state_s;
  end

  // Ring storage and 1-bit pointers; entries cleared so outputs read 0 out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        res_mem_r[i] <= {WIDTH{1'b0}};
        flg_mem_r[i] <= 3'b000;
      end
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
    end else begin
      if (push_s) begin
        res_mem_r[wr_ptr_r] <= core_result_s;
        flg_mem_r[wr_ptr_r] <= {core_carry_s, core_ovf_s, core_zero_s};
        wr_ptr_r            <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
    end
  end

  assign out_result   = res_mem_r[rd_ptr_r];
  assign out_carryout = flg_mem_r[rd_ptr_r][2];
  assign out_overflow = flg_mem_r[rd_ptr_r][1];
  assign out_zero     = flg_mem_r[rd_ptr_r][0];

  // Sticky overflow: a new overflow beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     sticky_r <= 1'b0;
    else if (push_s && core_ovf_s)  sticky_r <= 1'b1;
    else if (clr_sticky)            sticky_r <= 1'b0;
    else                            sticky_r <= sticky_r;
  end

  assign sticky_ovf = sticky_r;

`ifdef ALU_STAGE_OPCOUNT_EN
  logic [15:0] op_count_r;

  // Completed-operation counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          op_count_r <= 16'd0;
    else if (clr_sticky) op_count_r <= 16'd0;
    else if (pop_s)      op_count_r <= op_count_r + 16'd1;
    else                 op_count_r <= op_count_r;
  end

  assign op_count = op_count_r;
`endif

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered stage directly downstream of the combinational add/subtract/SLT datapath.
- Accepts one operation per cycle over valid/ready, evaluates it, and holds result plus flags in a 2-entry output buffer.
- Consumers stall the stage without losing operations.
- Tracks a sticky overflow flag and can optionally count completed operations for bring-up debug.

Parameters:
- WIDTH, 10, operand/result width in bits (minimum 2).
- DEPTH, 2, output buffer entries (fixed 2; listed for the package constant).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation offered
- in_ready  output  1  stage can accept this cycle
- in_cmd  input  2  0=ADD, 1=SUB, 2=SLT, 3=reserved
- in_a  input  WIDTH  operand A, two's complement
- in_b  input  WIDTH  operand B, two's complement
- out_valid  output  1  buffer head holds a result
- out_ready  input  1  consumer takes head this cycle
- out_result  output  WIDTH  head result
- out_carryout  output  1  head carry-out
- out_overflow  output  1  head signed overflow
- out_zero  output  1  head result == 0
- sticky_ovf  output  1  overflow seen since last clear
- clr_sticky  input  1  synchronous clear of sticky_ovf

Behaviour:
- Reset (async, rst_n=0):
  - buffer empty; out_valid=0.
  - out_result, out_carryout, out_overflow and out_zero all 0.
  - sticky_ovf=0; in_ready=1 after reset deasserts.
- Accept on clk edge when in_valid & in_ready. Push on accept; pop on out_valid & out_ready.
- Latency: accepted op appears at out_* the next cycle when the buffer was empty; otherwise it queues behind the head.
- Arithmetic:
  - ADD: {carry,result} = a+b.
  - SUB: a + ~b + 1; carry is that carry-out.
  - Overflow for ADD/SUB = operand signs equal (B inverted for SUB) and result sign differs.
  - SLT: computes a-b; result = {0..0, sign(a-b) XOR ovf(a-b)}; carryout=0, overflow=0.
  - Reserved cmd 3: result 0, flags 0, zero=1; still accepted and popped normally.
- Zero flag is computed on the final result.
- in_ready = !full | out_ready (simultaneous pop frees a slot the same cycle).
- Simultaneous push+pop:
  - when full: head leaves, new entry joins the tail; occupancy stays 2.
  - when occupancy is 1: new entry becomes head; occupancy stays 1.
- Empty with out_ready=1 and no push: no change; out_* hold their last values (don't-care to consumer).
- Buffer is a 1-bit-pointer ring with wrap-around.
- Occupancy states: EMPTY, ONE, FULL.
  - EMPTY -push-> ONE
  - ONE -push-> FULL
  - ONE -pop-> EMPTY
  - FULL -pop-> ONE
  - push+pop keeps the current state.
- sticky_ovf:
  - set when an accepted ADD/SUB produces overflow.
  - clr_sticky clears it; a set in the same cycle wins over a clear.
- Reset mid-operation: buffered entries discarded; nothing is replayed.

Optional Feature:
- Macro ALU_STAGE_OPCOUNT_EN.
- Defined:
  - adds output op_count (16 bits), incremented on every pop and wrapping 0xFFFF->0.
  - reset to 0; clr_sticky also clears it.
- Undefined: port and counter are absent; all other behaviour identical.

Decomposition:
- Shared package/include holds:
  - CMD_ADD/CMD_SUB/CMD_SLT/CMD_RSVD encodings
  - DEPTH constant
  - occupancy state encodings
- One sub-module, alu_addsub_core: purely combinational. Inputs: a, b, cmd. Outputs: result, carryout, overflow, zero.
- The stage instantiates the core once and owns all registers.

Test Plan:
- Reset with in_valid=1 held -> out_valid=0, sticky_ovf=0, in_ready=1 on the first cycle after release.
- SLT with a=0x000, b=0x1FF, out_ready=1 -> next cycle out_result=0x001, out_overflow=0, out_zero=0.
- ADD with a=0x1FF, b=0x001 -> out_result=0x200, carryout=0, overflow=1, sticky_ovf=1. Then clr_sticky -> sticky_ovf=0.
- SUB with a=0x200, b=0x001 -> result=0x1FF, overflow=1. Then SUB a=0x005, b=0x005 -> result=0, zero=1, carryout=1.
- out_ready=0, push 3 ADDs back-to-back -> in_ready drops after 2 accepts. Then raise out_ready -> results pop in order and the third op is accepted the same cycle as the first pop.
- rst_n pulsed low while FULL -> out_valid=0 immediately (async). With ALU_STAGE_OPCOUNT_EN, op_count=0.
